fme_reg_file: RTL and testbench

FME_REG_FILE -- requirements
Module: fme_reg_file

---
 rtl/fme_pkg.sv | 10 +
 rtl/fme_rf_clr_seq.sv | 58 +++++
 rtl/fme_reg_file.sv | 69 ++++++
 tb/tb_fme_reg_file.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fme_pkg.sv
// Shared types and default sizing for the FME register file.
package fme_pkg;
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } fme_state_e;

   localparam int FME_DATA_W = 32;
   localparam int FME_DEPTH  = 16;
endpackage

// File: rtl/fme_rf_clr_seq.sv
// Bulk-clear sequencer: walks every entry once, one per enabled cycle.
module fme_rf_clr_seq
   import fme_pkg::*;
#(
   parameter int DEPTH  = FME_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   fme_state_e        state;
   logic [ADDR_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (en && clr) begin
                  state <= ST_CLEAR;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               // en low stalls the walk with busy still asserted
               if (en) begin
                  if (cnt == LAST) begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                     busy  <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_we   = (state == ST_CLEAR) && en;
   assign clr_addr = cnt;
endmodule

// File: rtl/fme_reg_file.sv
// One-write, two-read register file with write-through bypass and bulk clear.
module fme_reg_file
   import fme_pkg::*;
#(
   parameter int DATA_W = FME_DATA_W,
   parameter int DEPTH  = FME_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              wr,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd,
   input  logic [ADDR_W-1:0] rd_addr0,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic              clr,
   output logic [DATA_W-1:0] rd_data0,
   output logic [DATA_W-1:0] rd_data1,
   output logic              rd_valid,
   output logic              busy
);
   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic                         clr_we;
   logic [ADDR_W-1:0]            clr_addr;
   logic                         idle_go;
   logic                         acc_wr;
   logic                         acc_rd;

   fme_rf_clr_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clr_seq (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clr      (clr),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // A clear request wins the cycle; wr/rd issued alongside it are dropped.
   assign idle_go = en && !busy && !clr;
   assign acc_wr  = idle_go && wr;
   assign acc_rd  = idle_go && rd;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem <= '0;
      end else if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (acc_wr) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data0 <= '0;
         rd_data1 <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= acc_rd;
         if (acc_rd) begin
            rd_data0 <= (acc_wr && wr_addr == rd_addr0) ? wr_data : mem[rd_addr0];
            rd_data1 <= (acc_wr && wr_addr == rd_addr1) ? wr_data : mem[rd_addr1];
         end
      end
   end
endmodule

// File: tb/tb_fme_reg_file.sv
// Randomized and directed check of fme_reg_file against an array-based model.
module tb_fme_reg_file;
   localparam int DW = 32;
   localparam int DP = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0, wr = 1'b0, rd = 1'b0, clr = 1'b0;
   logic [AW-1:0] wr_addr = '0, rd_addr0 = '0, rd_addr1 = '0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] rd_data0, rd_data1;
   logic          rd_valid, busy;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [DW-1:0] m_mem [DP];
   logic [DW-1:0] m_d0, m_d1;
   logic          m_vld;
   int            m_left;   // entries still to clear; 0 = not clearing

   fme_reg_file #(.DATA_W(DW), .DEPTH(DP)) dut (
      .clk(clk), .rst(rst), .en(en), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd(rd), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .clr(clr),
      .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_valid(rd_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DP; i++) m_mem[i] = '0;
      m_d0 = '0; m_d1 = '0; m_vld = 1'b0; m_left = 0;
   endtask

   task automatic check_outs(input string tag);
      chk({tag, ".valid"}, {31'b0, rd_valid}, {31'b0, m_vld});
      chk({tag, ".busy"},  {31'b0, busy},     {31'b0, m_left != 0});
      chk({tag, ".d0"},    rd_data0, m_d0);
      chk({tag, ".d1"},    rd_data1, m_d1);
   endtask

   // One clock with the given inputs; the model advances by the same rules.
   task automatic cyc(input logic e, input logic w, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic r, input logic [AW-1:0] a0,
                      input logic [AW-1:0] a1, input logic c, input string tag);
      en = e; wr = w; wr_addr = wa; wr_data = wd; rd = r; rd_addr0 = a0; rd_addr1 = a1; clr = c;
      @(posedge clk);
      m_vld = 1'b0;
      if (m_left != 0) begin
         if (e) begin
            m_mem[DP - m_left] = '0;
            m_left--;
         end
      end else if (e && c) begin
         m_left = DP;
      end else if (e) begin
         if (r) begin
            m_d0 = (w && wa == a0) ? wd : m_mem[a0];
            m_d1 = (w && wa == a1) ? wd : m_mem[a1];
            m_vld = 1'b1;
         end
         if (w) m_mem[wa] = wd;
      end
      #1;
      check_outs(tag);
   endtask

   task automatic idle_cyc(input string tag);
      cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, tag);
   endtask

   task automatic fill_all();
      for (int i = 0; i < DP; i++)
         cyc(1'b1, 1'b1, AW'(i), $urandom, 1'b0, '0, '0, 1'b0, "fill");
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < DP; i += 2)
         cyc(1'b1, 1'b0, '0, '0, 1'b1, AW'(i), AW'(i + 1), 1'b0, tag);
   endtask

   initial begin
      int nb;
      model_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outs("reset");
      @(negedge clk);
      rst = 1'b1;

      cyc(1'b1, 1'b0, '0, '0, 1'b1, AW'(0), AW'(15), 1'b0, "rd_after_reset");

      cyc(1'b1, 1'b1, AW'(3), 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, "wr3");
      cyc(1'b1, 1'b0, '0, '0, 1'b1, AW'(3), AW'(0), 1'b0, "rd3");
      chk("rd3.lit", rd_data0, 32'hDEADBEEF);
      idle_cyc("rd3.pulse_end");

      cyc(1'b1, 1'b1, AW'(5), 32'h12345678, 1'b1, AW'(5), AW'(5), 1'b0, "bypass");
      chk("bypass.lit0", rd_data0, 32'h12345678);
      chk("bypass.lit1", rd_data1, 32'h12345678);

      // full clear with writes to 7 attempted throughout
      fill_all();
      cyc(1'b1, 1'b1, AW'(7), 32'hA5A5A5A5, 1'b1, AW'(7), AW'(7), 1'b1, "clr_go");
      nb = 0;
      for (int k = 0; k < 40 && busy; k++) begin
         nb++;
         cyc(1'b1, 1'b1, AW'(7), 32'h5A5A5A5A, 1'b1, AW'(7), AW'(1), 1'b0, "clr_run");
      end
      chk("clr.busy_cycles", DW'(nb), 32'd16);
      read_all("after_clr");

      // stalled clear: en low for 3 cycles in the middle
      fill_all();
      cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, "stall_go");
      nb = 0;
      for (int k = 0; k < 60 && busy; k++) begin
         nb++;
         cyc((k < 5 || k > 7), 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, "stall_run");
      end
      chk("stall.busy_cycles", DW'(nb), 32'd19);
      read_all("after_stall");

      // reset at clear cycle 8
      fill_all();
      cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, "abort_go");
      for (int k = 0; k < 7; k++) idle_cyc("abort_run");
      rst = 1'b0;
      #1;
      model_reset();
      check_outs("abort.async");
      @(negedge clk);
      rst = 1'b1;
      read_all("after_abort");

      // en low: nothing changes, no valid pulse
      cyc(1'b1, 1'b1, AW'(9), 32'hCAFEF00D, 1'b1, AW'(9), AW'(2), 1'b0, "pre_hold");
      cyc(1'b0, 1'b1, AW'(9), 32'h0BADF00D, 1'b1, AW'(9), AW'(9), 1'b0, "en_low");
      cyc(1'b0, 1'b1, AW'(2), 32'h11111111, 1'b1, AW'(2), AW'(9), 1'b0, "en_low2");
      cyc(1'b1, 1'b0, '0, '0, 1'b1, AW'(9), AW'(2), 1'b0, "post_hold");

      // random traffic with occasional clears
      for (int k = 0; k < 600; k++) begin
         cyc($urandom_range(9, 0) != 0, $urandom_range(1, 0) == 1, AW'($urandom),
             $urandom, $urandom_range(1, 0) == 1, AW'($urandom), AW'($urandom),
             $urandom_range(49, 0) == 0, "rand");
      end
      for (int k = 0; k < 40 && busy; k++) idle_cyc("drain");
      read_all("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
